// File: rtl/m68k_bus_master.sv
// ============================================================================
// m68k_bus_master : 68000-style asynchronous bus initiator (AS/UDS/LDS/DTACK/BERR)
// Optional: define BUSMASTER_TIMEOUT_EN to abort S_WAIT after TIMEOUT_CYCLES.
// Revision: 1.0
// ============================================================================
`default_nettype none

module m68k_bus_master #(
   parameter int RECOVERY_CYCLES = 1,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_RW,
   input  logic        REQ_WORD,
   input  logic [23:0] REQ_ADDR,
   input  logic [15:0] REQ_WDATA,
   output logic        RSP_VALID,
   output logic        RSP_ERR,
   output logic [15:0] RSP_RDATA,
   output logic [22:0] ADDR,
   output logic        AS,
   output logic        UDS,
   output logic        LDS,
   output logic        RW,
   output logic [15:0] DATA_OUT,
   output logic        DATA_OE,
   input  logic [15:0] DATA_IN,
   input  logic        DTACK,
   input  logic        BERR
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_ADDR    = 4'd1,
      S_ASSERT  = 4'd2,
      S_WDS     = 4'd3,
      S_WAIT    = 4'd4,
      S_LATCH   = 4'd5,
      S_END     = 4'd6,
      S_RECOVER = 4'd7,
      S_ALIGN   = 4'd8
   } state_t;

   localparam int REC_W = (RECOVERY_CYCLES > 1) ? $clog2(RECOVERY_CYCLES) : 1;
   localparam logic [REC_W-1:0] REC_MAX = REC_W'(RECOVERY_CYCLES - 1);

   state_t           state_q;
   logic             dtack_d1_q, dtack_d2_q, berr_d1_q, berr_d2_q;
   logic             req_rw_q, req_word_q;
   logic [23:0]      req_addr_q;
   logic [15:0]      req_wdata_q;
   logic             err_q;
   logic [15:0]      rdata_q;
   logic [REC_W-1:0] rec_cnt_q;

   logic [22:0]      addr_q;
   logic             as_q, uds_q, lds_q, rw_q, data_oe_q;
   logic [15:0]      data_out_q;
   logic             rsp_valid_q, rsp_err_q;
   logic [15:0]      rsp_rdata_q;

`ifdef BUSMASTER_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] to_cnt_q;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

   // Even byte lives on D15..D8 (UDS), odd byte on D7..D0 (LDS).
   logic w_uds_n, w_lds_n;
   assign w_uds_n = !(req_word_q || !req_addr_q[0]);
   assign w_lds_n = !(req_word_q ||  req_addr_q[0]);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         dtack_d1_q  <= 1'b1;
         dtack_d2_q  <= 1'b1;
         berr_d1_q   <= 1'b1;
         berr_d2_q   <= 1'b1;
         req_rw_q    <= 1'b1;
         req_word_q  <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         rec_cnt_q   <= '0;
         addr_q      <= '0;
         as_q        <= 1'b1;
         uds_q       <= 1'b1;
         lds_q       <= 1'b1;
         rw_q        <= 1'b1;
         data_oe_q   <= 1'b0;
         data_out_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
`ifdef BUSMASTER_TIMEOUT_EN
         to_cnt_q    <= '0;
`endif
      end else begin
         dtack_d1_q  <= DTACK;
         dtack_d2_q  <= dtack_d1_q;
         berr_d1_q   <= BERR;
         berr_d2_q   <= berr_d1_q;
         rsp_valid_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (REQ_VALID) begin
                  req_rw_q    <= REQ_RW;
                  req_word_q  <= REQ_WORD;
                  req_addr_q  <= REQ_ADDR;
                  req_wdata_q <= REQ_WDATA;
                  err_q       <= 1'b0;
                  state_q     <= (REQ_WORD && REQ_ADDR[0]) ? S_ALIGN : S_ADDR;
               end
            end
            S_ALIGN: begin
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= 1'b1;
               rsp_rdata_q <= '0;
               state_q     <= S_IDLE;
            end
            S_ADDR: begin
               addr_q <= req_addr_q[23:1];
               rw_q   <= req_rw_q;
               if (!req_rw_q) begin
                  data_oe_q  <= 1'b1;
                  data_out_q <= req_word_q ? req_wdata_q
                                           : {req_wdata_q[7:0], req_wdata_q[7:0]};
               end
               state_q <= S_ASSERT;
            end
            S_ASSERT: begin
               as_q <= 1'b0;
`ifdef BUSMASTER_TIMEOUT_EN
               to_cnt_q <= '0;
`endif
               if (req_rw_q) begin
                  uds_q   <= w_uds_n;
                  lds_q   <= w_lds_n;
                  state_q <= S_WAIT;
               end else begin
                  state_q <= S_WDS;
               end
            end
            S_WDS: begin
               uds_q   <= w_uds_n;
               lds_q   <= w_lds_n;
`ifdef BUSMASTER_TIMEOUT_EN
               to_cnt_q <= '0;
`endif
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               // Bus error takes priority over a simultaneous DTACK.
               if (!berr_d2_q) begin
                  err_q   <= 1'b1;
                  state_q <= S_END;
               end else if (!dtack_d2_q) begin
                  state_q <= S_LATCH;
               end
`ifdef BUSMASTER_TIMEOUT_EN
               else if (to_cnt_q == TO_MAX) begin
                  err_q   <= 1'b1;
                  state_q <= S_END;
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
`endif
            end
            S_LATCH: begin
               rdata_q <= req_word_q     ? DATA_IN :
                          req_addr_q[0]  ? {8'h00, DATA_IN[7:0]}
                                         : {8'h00, DATA_IN[15:8]};
               state_q <= S_END;
            end
            S_END: begin
               // Address, RW and write data stay on the bus for this hold cycle.
               as_q        <= 1'b1;
               uds_q       <= 1'b1;
               lds_q       <= 1'b1;
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= err_q;
               rsp_rdata_q <= err_q ? 16'h0000 : rdata_q;
               rec_cnt_q   <= '0;
               state_q     <= S_RECOVER;
            end
            S_RECOVER: begin
               rw_q      <= 1'b1;
               data_oe_q <= 1'b0;
               if (rec_cnt_q != REC_MAX) begin
                  rec_cnt_q <= rec_cnt_q + 1'b1;
               end else if (dtack_d2_q && berr_d2_q) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign REQ_READY = (state_q == S_IDLE);
   assign RSP_VALID = rsp_valid_q;
   assign RSP_ERR   = rsp_err_q;
   assign RSP_RDATA = rsp_rdata_q;
   assign ADDR      = addr_q;
   assign AS        = as_q;
   assign UDS       = uds_q;
   assign LDS       = lds_q;
   assign RW        = rw_q;
   assign DATA_OUT  = data_out_q;
   assign DATA_OE   = data_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_m68k_bus_master.sv
// Directed testbench for m68k_bus_master (RECOVERY_CYCLES=3, TIMEOUT_CYCLES=16).
`default_nettype none
`timescale 1ns/1ps

module tb_m68k_bus_master;

   logic        CLK = 1'b0;
   logic        RST;
   logic        REQ_VALID, REQ_READY, REQ_RW, REQ_WORD;
   logic [23:0] REQ_ADDR;
   logic [15:0] REQ_WDATA;
   logic        RSP_VALID, RSP_ERR;
   logic [15:0] RSP_RDATA;
   logic [22:0] ADDR;
   logic        AS, UDS, LDS, RW;
   logic [15:0] DATA_OUT;
   logic        DATA_OE;
   logic [15:0] DATA_IN;
   logic        DTACK, BERR;

   int checks = 0;
   int errors = 0;

   m68k_bus_master #(.RECOVERY_CYCLES(3), .TIMEOUT_CYCLES(16)) dut (
      .CLK(CLK), .RST(RST),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_RW(REQ_RW),
      .REQ_WORD(REQ_WORD), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
      .RSP_VALID(RSP_VALID), .RSP_ERR(RSP_ERR), .RSP_RDATA(RSP_RDATA),
      .ADDR(ADDR), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW),
      .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .DATA_IN(DATA_IN),
      .DTACK(DTACK), .BERR(BERR)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!REQ_READY && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (REQ_READY !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_timeout: REQ_READY=%b required 1", tag, REQ_READY);
      end
   endtask

   // Leaves the bench just after the accept edge (T0).
   task automatic start_req(input logic rw, input logic word, input logic [23:0] a,
                            input logic [15:0] wd);
      REQ_RW = rw; REQ_WORD = word; REQ_ADDR = a; REQ_WDATA = wd;
      REQ_VALID = 1'b1;
      tick();
      REQ_VALID = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) tick();
      checks++;
      if ({AS, UDS, LDS, RW, DATA_OE, REQ_READY, RSP_VALID, RSP_ERR} !== 8'b1111_0100) begin
         errors++;
         $display("FAIL reset_ctrl: AS UDS LDS RW OE RDY RV RE=%b required 11110100",
                  {AS, UDS, LDS, RW, DATA_OE, REQ_READY, RSP_VALID, RSP_ERR});
      end
      checks++;
      if (ADDR !== 23'h0 || DATA_OUT !== 16'h0 || RSP_RDATA !== 16'h0) begin
         errors++;
         $display("FAIL reset_data: ADDR=%h DATA_OUT=%h RSP_RDATA=%h required 0", ADDR, DATA_OUT, RSP_RDATA);
      end
      RST = 1'b0;
      tick();
   endtask

   task automatic test_word_read();
      wait_ready("word_read");
      DTACK = 1'b0; DATA_IN = 16'hBEEF;
      repeat (3) tick();
      start_req(1'b1, 1'b1, 24'hF00000, 16'h0);
      checks++;
      if (REQ_READY !== 1'b0) begin
         errors++; $display("FAIL wr_ready_t0: REQ_READY=%b required 0", REQ_READY);
      end
      for (int t = 1; t <= 6; t++) begin
         tick();
         if (t == 1) begin
            checks++;
            if (ADDR !== 23'h780000 || RW !== 1'b1 || AS !== 1'b1) begin
               errors++; $display("FAIL rd_t1: ADDR=%h RW=%b AS=%b required 780000 1 1", ADDR, RW, AS);
            end
         end
         if (t == 2) begin
            checks++;
            if ({AS, UDS, LDS} !== 3'b000) begin
               errors++; $display("FAIL rd_strobes_t2: AS UDS LDS=%b required 000", {AS, UDS, LDS});
            end
         end
         if (t == 4) begin
            checks++;
            if (RSP_VALID !== 1'b0) begin
               errors++; $display("FAIL rd_early_rsp: RSP_VALID=%b at T4 required 0", RSP_VALID);
            end
         end
         if (t == 5) begin
            checks++;
            if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b0 || RSP_RDATA !== 16'hBEEF || AS !== 1'b1) begin
               errors++;
               $display("FAIL rd_rsp_t5: RV=%b RE=%b RDATA=%h AS=%b required 1 0 beef 1",
                        RSP_VALID, RSP_ERR, RSP_RDATA, AS);
            end
         end
         if (t == 6) begin
            checks++;
            if (RSP_VALID !== 1'b0 || RSP_RDATA !== 16'hBEEF) begin
               errors++; $display("FAIL rd_rsp_hold: RV=%b RDATA=%h required 0 beef", RSP_VALID, RSP_RDATA);
            end
         end
      end
      DTACK = 1'b1;
   endtask

   task automatic test_byte_write();
      wait_ready("byte_write");
      DTACK = 1'b0; DATA_IN = 16'h0000;
      repeat (3) tick();
      start_req(1'b0, 1'b0, 24'hFF8003, 16'h125A);
      for (int t = 1; t <= 7; t++) begin
         tick();
         if (t == 1) begin
            checks++;
            if (ADDR !== 23'h7FC001 || DATA_OUT !== 16'h5A5A || DATA_OE !== 1'b1 || RW !== 1'b0) begin
               errors++;
               $display("FAIL bw_t1: ADDR=%h DOUT=%h OE=%b RW=%b required 7fc001 5a5a 1 0",
                        ADDR, DATA_OUT, DATA_OE, RW);
            end
         end
         if (t == 2) begin
            checks++;
            if ({AS, UDS, LDS} !== 3'b011) begin
               errors++; $display("FAIL bw_t2: AS UDS LDS=%b required 011", {AS, UDS, LDS});
            end
         end
         if (t == 3) begin
            checks++;
            if ({AS, UDS, LDS} !== 3'b010) begin
               errors++; $display("FAIL bw_t3: AS UDS LDS=%b required 010", {AS, UDS, LDS});
            end
         end
         if (t == 5) begin
            checks++;
            if (RSP_VALID !== 1'b0) begin
               errors++; $display("FAIL bw_early_rsp: RSP_VALID=%b required 0", RSP_VALID);
            end
         end
         if (t == 6) begin
            checks++;
            if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b0 || DATA_OE !== 1'b1 || {AS, LDS} !== 2'b11) begin
               errors++;
               $display("FAIL bw_t6: RV=%b RE=%b OE=%b AS LDS=%b required 1 0 1 11",
                        RSP_VALID, RSP_ERR, DATA_OE, {AS, LDS});
            end
         end
         if (t == 7) begin
            checks++;
            if (DATA_OE !== 1'b0 || RW !== 1'b1) begin
               errors++; $display("FAIL bw_t7: OE=%b RW=%b required 0 1", DATA_OE, RW);
            end
         end
      end
      DTACK = 1'b1;
   endtask

   task automatic test_word_write();
      wait_ready("word_write");
      DTACK = 1'b0;
      repeat (3) tick();
      start_req(1'b0, 1'b1, 24'h000200, 16'h1234);
      for (int t = 1; t <= 3; t++) begin
         tick();
         if (t == 1) begin
            checks++;
            if (DATA_OUT !== 16'h1234 || ADDR !== 23'h000100) begin
               errors++; $display("FAIL ww_t1: DOUT=%h ADDR=%h required 1234 000100", DATA_OUT, ADDR);
            end
         end
         if (t == 3) begin
            checks++;
            if ({AS, UDS, LDS} !== 3'b000) begin
               errors++; $display("FAIL ww_t3: AS UDS LDS=%b required 000", {AS, UDS, LDS});
            end
         end
      end
      repeat (3) tick();
      DTACK = 1'b1;
   endtask

   task automatic test_byte_read(input logic [23:0] a, input logic [2:0] strb,
                                 input logic [15:0] exp, input string tag);
      wait_ready(tag);
      DTACK = 1'b0; DATA_IN = 16'hA55A;
      repeat (3) tick();
      start_req(1'b1, 1'b0, a, 16'h0);
      for (int t = 1; t <= 5; t++) begin
         tick();
         if (t == 2) begin
            checks++;
            if ({AS, UDS, LDS} !== strb) begin
               errors++; $display("FAIL %s_lanes: AS UDS LDS=%b required %b", tag, {AS, UDS, LDS}, strb);
            end
         end
         if (t == 5) begin
            checks++;
            if (RSP_VALID !== 1'b1 || RSP_RDATA !== exp) begin
               errors++; $display("FAIL %s_data: RV=%b RDATA=%h required 1 %h", tag, RSP_VALID, RSP_RDATA, exp);
            end
         end
      end
      DTACK = 1'b1;
   endtask

   task automatic test_misaligned();
      wait_ready("misaligned");
      start_req(1'b1, 1'b1, 24'h000101, 16'h0);
      tick();
      checks++;
      if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1 || RSP_RDATA !== 16'h0 || REQ_READY !== 1'b1) begin
         errors++;
         $display("FAIL align_rsp: RV=%b RE=%b RDATA=%h RDY=%b required 1 1 0000 1",
                  RSP_VALID, RSP_ERR, RSP_RDATA, REQ_READY);
      end
      checks++;
      if ({AS, UDS, LDS} !== 3'b111) begin
         errors++; $display("FAIL align_strobes: AS UDS LDS=%b required 111", {AS, UDS, LDS});
      end
      tick();
      checks++;
      if (RSP_VALID !== 1'b0 || AS !== 1'b1) begin
         errors++; $display("FAIL align_after: RV=%b AS=%b required 0 1", RSP_VALID, AS);
      end
   endtask

   task automatic test_berr_dtack();
      wait_ready("berr");
      DTACK = 1'b0; BERR = 1'b0; DATA_IN = 16'hFFFF;
      repeat (3) tick();
      start_req(1'b1, 1'b1, 24'h000400, 16'h0);
      for (int t = 1; t <= 10; t++) begin
         tick();
         if (t == 4) begin
            checks++;
            if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1 || RSP_RDATA !== 16'h0) begin
               errors++;
               $display("FAIL berr_rsp: RV=%b RE=%b RDATA=%h required 1 1 0000", RSP_VALID, RSP_ERR, RSP_RDATA);
            end
         end
         if (t == 10) begin
            checks++;
            if (REQ_READY !== 1'b0) begin
               errors++; $display("FAIL berr_held: REQ_READY=%b required 0", REQ_READY);
            end
         end
      end
      DTACK = 1'b1;
      repeat (5) tick();
      checks++;
      if (REQ_READY !== 1'b0) begin
         errors++; $display("FAIL berr_only_held: REQ_READY=%b required 0", REQ_READY);
      end
      BERR = 1'b1;
      wait_ready("berr_release");
   endtask

   task automatic test_recovery();
      wait_ready("recovery");
      DTACK = 1'b0; DATA_IN = 16'h1357;
      repeat (3) tick();
      start_req(1'b1, 1'b1, 24'h000800, 16'h0);
      for (int t = 1; t <= 8; t++) begin
         tick();
         if (t == 3) DTACK = 1'b1;
         if (t == 5) begin
            checks++;
            if (RSP_VALID !== 1'b1 || RSP_RDATA !== 16'h1357) begin
               errors++; $display("FAIL rec_rsp: RV=%b RDATA=%h required 1 1357", RSP_VALID, RSP_RDATA);
            end
         end
         if (t == 7) begin
            checks++;
            if (REQ_READY !== 1'b0) begin
               errors++; $display("FAIL rec_min: REQ_READY=%b at T7 required 0", REQ_READY);
            end
         end
         if (t == 8) begin
            checks++;
            if (REQ_READY !== 1'b1) begin
               errors++; $display("FAIL rec_exit: REQ_READY=%b at T8 required 1", REQ_READY);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int  gap = 0;
      int  phase = 0;
      wait_ready("b2b");
      DTACK = 1'b0; DATA_IN = 16'h2468;
      repeat (3) tick();
      REQ_RW = 1'b1; REQ_WORD = 1'b1; REQ_ADDR = 24'h001000; REQ_WDATA = 16'h0;
      REQ_VALID = 1'b1;
      // phase 0: first AS low pending, 1: first cycle on bus, 2: counting AS-high gap
      for (int t = 0; t < 60 && phase < 3; t++) begin
         tick();
         if (phase == 0 && AS === 1'b0) phase = 1;
         else if (phase == 1 && AS === 1'b1) begin phase = 2; gap = 1; end
         else if (phase == 2) begin
            if (AS === 1'b1) begin
               gap++;
               if (gap == 2) DTACK = 1'b1;
               if (REQ_READY === 1'b1) DTACK = 1'b0;
               if (REQ_READY === 1'b0 && DTACK === 1'b0) REQ_VALID = 1'b0;
            end else phase = 3;
         end
      end
      REQ_VALID = 1'b0;
      checks++;
      if (phase != 3 || gap < 3) begin
         errors++; $display("FAIL b2b_gap: AS-high cycles=%0d phase=%0d required >=3 and phase 3", gap, phase);
      end
      repeat (4) tick();
      DTACK = 1'b1;
   endtask

`ifdef BUSMASTER_TIMEOUT_EN
   task automatic test_timeout();
      wait_ready("timeout");
      DTACK = 1'b1; BERR = 1'b1;
      start_req(1'b1, 1'b1, 24'h002000, 16'h0);
      for (int t = 1; t <= 19; t++) begin
         tick();
         if (t == 18) begin
            checks++;
            if (RSP_VALID !== 1'b0) begin
               errors++; $display("FAIL to_early: RSP_VALID=%b at T18 required 0", RSP_VALID);
            end
         end
         if (t == 19) begin
            checks++;
            if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1 || RSP_RDATA !== 16'h0) begin
               errors++;
               $display("FAIL to_rsp: RV=%b RE=%b RDATA=%h required 1 1 0000", RSP_VALID, RSP_ERR, RSP_RDATA);
            end
         end
      end
   endtask
`endif

   task automatic test_reset_mid_cycle();
      logic saw_rsp = 1'b0;
      wait_ready("mid_reset");
      DTACK = 1'b1; BERR = 1'b1;
      start_req(1'b1, 1'b1, 24'h000A00, 16'h0);
      repeat (6) tick();
      checks++;
      if (AS !== 1'b0) begin
         errors++; $display("FAIL mid_wait: AS=%b required 0", AS);
      end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      checks++;
      if ({AS, UDS, LDS, REQ_READY, RSP_VALID} !== 5'b11110 || ADDR !== 23'h0 || RSP_RDATA !== 16'h0) begin
         errors++;
         $display("FAIL mid_reset: AS UDS LDS RDY RV=%b ADDR=%h RDATA=%h required 11110 0 0",
                  {AS, UDS, LDS, REQ_READY, RSP_VALID}, ADDR, RSP_RDATA);
      end
      for (int t = 0; t < 6; t++) begin
         tick();
         if (RSP_VALID === 1'b1) saw_rsp = 1'b1;
      end
      checks++;
      if (saw_rsp !== 1'b0) begin
         errors++; $display("FAIL mid_reset_drop: response seen=%b required 0", saw_rsp);
      end
   endtask

   initial begin
      RST = 1'b1; REQ_VALID = 1'b0; REQ_RW = 1'b1; REQ_WORD = 1'b0;
      REQ_ADDR = '0; REQ_WDATA = '0; DATA_IN = '0; DTACK = 1'b1; BERR = 1'b1;
      test_reset();
      test_word_read();
      test_byte_write();
      test_word_write();
      test_byte_read(24'h000010, 3'b001, 16'h00A5, "br_even");
      test_byte_read(24'h000011, 3'b010, 16'h005A, "br_odd");
      test_misaligned();
      test_berr_dtack();
      test_recovery();
      test_back_to_back();
`ifdef BUSMASTER_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_cycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/m68k_bus_master.md
Name: m68k_bus_master

Overview:
Initiator side of the 68000-style asynchronous bus (AS/UDS/LDS/RW/DTACK/BERR). It converts single requests from an on-chip host port (debug loader, DMA helper) into byte or word bus cycles, then waits for DTACK or BERR from any responder. It returns read data or an error on a response port. It sits between the host logic and the shared address/data bus, upstream of the system controller's decode and DTACK aggregation.

Parameters:
RECOVERY_CYCLES, 1, minimum CLK cycles with all strobes negated between bus cycles (>=1)
TIMEOUT_CYCLES, 64, S_WAIT cycles before abort; used only with BUSMASTER_TIMEOUT_EN (>=2)

Ports:
CLK  in  1  system clock
RST  in  1  reset; synchronous, active-high
REQ_VALID  in  1  host request valid
REQ_READY  out  1  high only in S_IDLE
REQ_RW  in  1  1=read, 0=write
REQ_WORD  in  1  1=16-bit, 0=byte
REQ_ADDR  in  24  byte address
REQ_WDATA  in  16  write data; byte writes use [7:0]
RSP_VALID  out  1  one-cycle response pulse
RSP_ERR  out  1  error flag, valid with RSP_VALID
RSP_RDATA  out  16  read data, valid with RSP_VALID
ADDR  out  23  bus address A23..A1
AS, UDS, LDS  out  1  active-low strobes
RW  out  1  1=read
DATA_OUT  out  16  bus write data
DATA_OE  out  1  data bus driver enable
DATA_IN  in  16  bus read data
DTACK, BERR  in  1  active-low, asynchronous to CLK

Behaviour:
- Reset values: AS=UDS=LDS=1, RW=1, ADDR=0, DATA_OUT=0, DATA_OE=0, REQ_READY=1, RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0. DTACK/BERR synchronizers reset to 1. State=S_IDLE.
- DTACK and BERR each pass through a 2-flop synchronizer (d1, d2). The FSM uses only d2.
- States: S_IDLE, S_ADDR, S_ASSERT, S_WDS, S_WAIT, S_LATCH, S_END, S_RECOVER, S_ALIGN.
- S_IDLE: on REQ_VALID && REQ_READY, latch the request. Word request with REQ_ADDR[0]=1 -> S_ALIGN. Otherwise -> S_ADDR.
- S_ALIGN: no strobe is asserted. Next cycle is S_IDLE with RSP_VALID=1, RSP_ERR=1, RSP_RDATA=0.
- S_ADDR: drive ADDR=REQ_ADDR[23:1] and RW. Writes: DATA_OE=1, DATA_OUT=REQ_WDATA (word) or {b,b} with b=REQ_WDATA[7:0] (byte). AS stays negated.
- S_ASSERT: AS=0. Reads also assert data strobes this cycle: word -> UDS=LDS=0; byte -> UDS if ADDR[0]=0, LDS if ADDR[0]=1. Reads -> S_WAIT; writes -> S_WDS.
- S_WDS (writes only): assert data strobes with the same lane rules; -> S_WAIT.
- S_WAIT: if BERR_d2=0 -> S_END with error. BERR wins over a simultaneous DTACK. Else if DTACK_d2=0 -> S_LATCH. Else stay.
- S_LATCH: capture DATA_IN at exit. Word: RSP_RDATA=DATA_IN. Byte: {8'h00, DATA_IN[15:8]} for even address, {8'h00, DATA_IN[7:0]} for odd. -> S_END.
- S_END: AS=UDS=LDS=1. ADDR, RW, DATA_OE and DATA_OUT are held for this cycle (write hold). RSP_VALID=1 for one cycle; RSP_ERR=1 and RSP_RDATA=0 on error. -> S_RECOVER.
- S_RECOVER: RW=1, DATA_OE=0. Stay at least RECOVERY_CYCLES cycles, then until DTACK_d2=1 and BERR_d2=1. -> S_IDLE.
- RSP_RDATA holds its value until the next response. There is no response backpressure.
- REQ_VALID outside S_IDLE is ignored.
- ADDR holds its last value while idle.
- RST asserted mid-cycle: next edge applies all reset values, drops the response, and enters S_IDLE directly.
- Latency with DTACK held low before the cycle starts, accept at T0: read RSP_VALID at T5; write at T6.

Optional Feature:
BUSMASTER_TIMEOUT_EN: defined -> a counter clears on S_WAIT entry and increments each S_WAIT cycle. Reaching TIMEOUT_CYCLES with neither DTACK_d2 nor BERR_d2 low -> S_END with RSP_ERR=1, RSP_RDATA=0. Undefined -> S_WAIT waits indefinitely and TIMEOUT_CYCLES is unused.

Test Plan:
- Word read 0xF00000, DTACK low, DATA_IN=0xBEEF -> AS low T2, UDS=LDS=0 T2, RSP_VALID T5, RSP_RDATA=0xBEEF, RSP_ERR=0.
- Byte write 0xFF8003 data 0x5A -> ADDR=0x7FC001, DATA_OUT=0x5A5A, DATA_OE=1 from T1, LDS low T3 and UDS high, RSP_VALID T6, DATA_OE=0 T7.
- Word read addr 0x000101 -> no AS/DS assertion, RSP_VALID=1 with RSP_ERR=1 one cycle after accept.
- DTACK and BERR both low on the same sample -> RSP_ERR=1, RSP_RDATA=0; REQ_READY stays low until both are released.
- Reads back-to-back with RECOVERY_CYCLES=3, DTACK released 1 cycle after AS high -> at least 3 cycles of AS high between cycles.
- BUSMASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, no DTACK -> RSP_ERR=1 after 16 S_WAIT cycles. RST pulsed in S_WAIT -> strobes high next edge, no RSP_VALID.
